carry_nibble_accum: RTL and testbench

- Sequential stage directly downstream of the 4-bit carry block.
- Adds two WIDTH-bit operands one nibble per cycle, least-significant nibble first.
- Each nibble's carry-out is registered and fed back as the next nibble's carry-in, as a chained carry block would do.
- Valid/ready handshake on the operand side and the result side; used in carry-chain test fabrics where a narrow carry primitive is time-multiplexed.

---
 rtl/carry_nibble_accum.sv | 125 ++++++++++++
 tb/tb_carry_nibble_accum.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/carry_nibble_accum.sv
// carry_nibble_accum: nibble-serial WIDTH-bit adder with registered carry chaining.
// Optional overflow output OVF is enabled by defining CARRY_NIBBLE_ACCUM_OVF_EN.
module carry_nibble_accum #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             A_VALID,
    output logic             A_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             S_VALID,
    input  logic             S_READY,
    output logic [WIDTH-1:0] S,
    output logic             COUT
`ifdef CARRY_NIBBLE_ACCUM_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("carry_nibble_accum: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             carry;
    logic             cout_reg;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       sum5;

    assign last  = (cnt == CW'(NIB - 1));
    assign a_nib = a_reg[{cnt, 2'b00} +: 4];
    assign b_nib = b_reg[{cnt, 2'b00} +: 4];
    assign sum5  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (A_VALID) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (S_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result bits are written in place; S only reads as valid in DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (A_VALID) begin
                        a_reg <= A;
                        b_reg <= B;
                        carry <= CIN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    s_reg[{cnt, 2'b00} +: 4] <= sum5[3:0];
                    carry <= sum5[4];
                    if (last) begin
                        cout_reg <= sum5[4];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CARRY_NIBBLE_ACCUM_OVF_EN
    logic ovf_reg;

    // Carry into the top bit is recovered from the top nibble's sum bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_reg <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_reg <= a_nib[3] ^ b_nib[3] ^ sum5[3] ^ sum5[4];
        end
    end

    assign OVF = ovf_reg;
`endif

    assign A_READY = (state == IDLE);
    assign S_VALID = (state == DONE);
    assign S       = s_reg;
    assign COUT    = cout_reg;

endmodule

// File: tb/tb_carry_nibble_accum.sv
// Directed table-driven bench for carry_nibble_accum (WIDTH=8).
// OVF checks compile in when CARRY_NIBBLE_ACCUM_OVF_EN is defined.
module tb_carry_nibble_accum;

    localparam int WIDTH = 8;
    localparam int NIB   = WIDTH / 4;

    logic             CLK;
    logic             RST;
    logic             A_VALID;
    logic             A_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             S_VALID;
    logic             S_READY;
    logic [WIDTH-1:0] S;
    logic             COUT;
`ifdef CARRY_NIBBLE_ACCUM_OVF_EN
    logic             OVF;
`endif

    int checks;
    int errors;

    carry_nibble_accum #(.WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .A_VALID(A_VALID),
        .A_READY(A_READY),
        .A      (A),
        .B      (B),
        .CIN    (CIN),
        .S_VALID(S_VALID),
        .S_READY(S_READY),
        .S      (S),
        .COUT   (COUT)
`ifdef CARRY_NIBBLE_ACCUM_OVF_EN
        ,
        .OVF    (OVF)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Accept one operand pair; returns cycles from accept edge to S_VALID.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                            input logic cin, output int lat);
        int n;
        n = 0;
        while (!A_READY && n < 50) begin
            step();
            n++;
        end
        chk("a_ready_wait", {31'd0, A_READY}, 32'd1);
        A       = a;
        B       = b;
        CIN     = cin;
        A_VALID = 1'b1;
        step();
        A_VALID = 1'b0;
        chk("a_ready_in_run", {31'd0, A_READY}, 32'd0);
        lat = 0;
        while (!S_VALID && lat < 50) begin
            A   = 8'($urandom);
            B   = 8'($urandom);
            CIN = 1'($urandom);
            step();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        chk({tag, "_lat"}, lat, NIB);
        chk({tag, "_svalid"}, {31'd0, S_VALID}, 32'd1);
        chk({tag, "_s"}, {24'd0, S}, {24'd0, v.s});
        chk({tag, "_cout"}, {31'd0, COUT}, {31'd0, v.cout});
`ifdef CARRY_NIBBLE_ACCUM_OVF_EN
        chk({tag, "_ovf"}, {31'd0, OVF}, {31'd0, v.ovf});
`endif
    endtask

    initial begin
        int   lat;
        vec_t v;
        logic [7:0] s_hold;
        logic c_hold;

        checks  = 0;
        errors  = 0;
        RST     = 1'b1;
        A_VALID = 1'b0;
        A       = '0;
        B       = '0;
        CIN     = 1'b0;
        S_READY = 1'b0;

        vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[8] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};

        step();
        step();
        RST = 1'b0;
        chk("rst_a_ready", {31'd0, A_READY}, 32'd1);
        chk("rst_s_valid", {31'd0, S_VALID}, 32'd0);
        chk("rst_s", {24'd0, S}, 32'd0);
        chk("rst_cout", {31'd0, COUT}, 32'd0);
`ifdef CARRY_NIBBLE_ACCUM_OVF_EN
        chk("rst_ovf", {31'd0, OVF}, 32'd0);
`endif

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            check_result($sformatf("vec%0d", i), vecs[i], lat);
            S_READY = 1'b1;
            step();
            S_READY = 1'b0;
            chk($sformatf("vec%0d_hs_svalid", i), {31'd0, S_VALID}, 32'd0);
            chk($sformatf("vec%0d_hs_aready", i), {31'd0, A_READY}, 32'd1);
            chk($sformatf("vec%0d_hold_s", i), {24'd0, S}, {24'd0, vecs[i].s});
        end

        // Backpressure: result frozen, new operands ignored while in DONE.
        v = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
        start_op(v.a, v.b, v.cin, lat);
        check_result("bp", v, lat);
        for (int i = 0; i < 10; i++) begin
            A_VALID = 1'b1;
            A       = 8'h11;
            B       = 8'h22;
            step();
            chk($sformatf("bp_svalid_%0d", i), {31'd0, S_VALID}, 32'd1);
            chk($sformatf("bp_aready_%0d", i), {31'd0, A_READY}, 32'd0);
            chk($sformatf("bp_s_%0d", i), {24'd0, S}, 32'h96);
            chk($sformatf("bp_cout_%0d", i), {31'd0, COUT}, 32'd0);
        end
        A_VALID = 1'b0;
        S_READY = 1'b1;
        step();
        S_READY = 1'b0;
        chk("bp_release_svalid", {31'd0, S_VALID}, 32'd0);
        chk("bp_release_aready", {31'd0, A_READY}, 32'd1);
        step();
        chk("bp_idle_svalid", {31'd0, S_VALID}, 32'd0);

        // Reset after the first nibble edge discards the carry-generating op.
        A       = 8'hFF;
        B       = 8'h01;
        CIN     = 1'b1;
        A_VALID = 1'b1;
        step();
        A_VALID = 1'b0;
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mrst_aready", {31'd0, A_READY}, 32'd1);
        chk("mrst_svalid", {31'd0, S_VALID}, 32'd0);
        chk("mrst_s", {24'd0, S}, 32'd0);
        chk("mrst_cout", {31'd0, COUT}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mrst_idle_svalid_%0d", i), {31'd0, S_VALID}, 32'd0);
        end
        v = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        start_op(v.a, v.b, v.cin, lat);
        check_result("post_rst", v, lat);

        // Reset while holding a valid result.
        s_hold = S;
        c_hold = COUT;
        chk("done_hold_s", {24'd0, s_hold}, 32'h02);
        chk("done_hold_c", {31'd0, c_hold}, 32'd0);
        S_READY = 1'b1;
        RST     = 1'b1;
        step();
        RST     = 1'b0;
        S_READY = 1'b0;
        chk("drst_svalid", {31'd0, S_VALID}, 32'd0);
        chk("drst_aready", {31'd0, A_READY}, 32'd1);
        chk("drst_s", {24'd0, S}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
